// File: rtl/d_reg_pkg.sv
// d_reg_pkg -- shared definitions for the d_reg_bank register bank.
//   mode_e      : global bank operation encoding (hold/load/shift/clear)
//   even_parity : width-generic even-parity helper, used only when
//                 D_REG_BANK_PARITY_EN is defined. Callers zero-extend
//                 their operand to PAR_MAX_W; zero bits leave the parity unchanged.
package d_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  localparam int PAR_MAX_W = 256;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/d_reg_chan.sv
// d_reg_chan -- one WIDTH-bit storage channel of d_reg_bank.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (loads RESET_VAL)
//   mode      : global bank operation
//   en        : this channel's load/clear enable (ignored by shift)
//   d         : parallel load word
//   shift_in  : word shifted in (sin for channel 0, previous channel otherwise)
//   q         : registered channel contents
//   q_par     : registered even parity of q (only with D_REG_BANK_PARITY_EN)
module d_reg_chan
  import d_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            mode,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] shift_in,
  output logic [WIDTH-1:0] q
`ifdef D_REG_BANK_PARITY_EN
  ,
  output logic             q_par
`endif
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  always_comb begin
    w_q_next = r_q;
    case (mode)
      MODE_LOAD:  if (en) w_q_next = d;
      MODE_SHIFT: w_q_next = shift_in;
      MODE_CLEAR: if (en) w_q_next = RESET_VAL;
      default:    w_q_next = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_q <= RESET_VAL;
    else     r_q <= w_q_next;
  end

  assign q = r_q;

`ifdef D_REG_BANK_PARITY_EN
  // Parity is computed from the next value so it lands on the same edge as q.
  logic r_par;
  always_ff @(posedge clk) begin
    if (rst) r_par <= even_parity(PAR_MAX_W'(RESET_VAL));
    else     r_par <= even_parity(PAR_MAX_W'(w_q_next));
  end
  assign q_par = r_par;
`else
  // Parity disabled: the channel carries no extra state.
`endif

endmodule

// File: rtl/d_reg_bank.sv
// d_reg_bank -- CHANNELS x WIDTH register bank with a snapshot port.
// Optional feature macro: D_REG_BANK_PARITY_EN (adds q_par / snap_par).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   d, en      : parallel load data / per-channel load-clear enables
//   mode       : 00 hold, 01 load, 10 shift, 11 clear
//   sin, sout  : shift-in word for channel 0 / combinational last channel
//   q          : registered bank contents, channel i = q[i*WIDTH +: WIDTH]
//   snap_req   : capture request; snap_ready: consumer accepts
//   snap_valid : snapshot pending; snap_data: captured bank
//   snap_ovf   : sticky dropped-request flag, cleared by ovf_clr
//   q_par, snap_par : per-channel even parity of q / snap_data (macro only)
module d_reg_bank
  import d_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       en,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          sin,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [WIDTH-1:0]          sout,
  input  logic                      snap_req,
  input  logic                      snap_ready,
  output logic                      snap_valid,
  output logic [CHANNELS*WIDTH-1:0] snap_data,
  output logic                      snap_ovf,
  input  logic                      ovf_clr
`ifdef D_REG_BANK_PARITY_EN
  ,
  output logic [CHANNELS-1:0]       q_par,
  output logic [CHANNELS-1:0]       snap_par
`endif
);

  logic [WIDTH-1:0] w_chan_q [CHANNELS];
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] w_shift_in;
      if (gi == 0) begin : g_head
        assign w_shift_in = sin;
      end else begin : g_tail
        assign w_shift_in = w_chan_q[gi-1];
      end

      d_reg_chan #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .mode    (w_mode),
        .en      (en[gi]),
        .d       (d[gi*WIDTH +: WIDTH]),
        .shift_in(w_shift_in),
        .q       (w_chan_q[gi])
`ifdef D_REG_BANK_PARITY_EN
        ,
        .q_par   (q_par[gi])
`endif
      );

      assign q[gi*WIDTH +: WIDTH] = w_chan_q[gi];
    end
  endgenerate

  assign sout = w_chan_q[CHANNELS-1];

  // Snapshot handshake. A new capture may replace a pending one only in the
  // cycle it is consumed, so snap_data never changes under a waiting reader.
  logic                      r_snap_valid;
  logic [CHANNELS*WIDTH-1:0] r_snap_data;
  logic                      r_snap_ovf;
  logic                      w_consume;
  logic                      w_accept;
  logic                      w_drop;

  assign w_consume = r_snap_valid & snap_ready;
  assign w_accept  = snap_req & (~r_snap_valid | snap_ready);
  assign w_drop    = snap_req & r_snap_valid & ~snap_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_valid <= 1'b0;
      r_snap_data  <= '0;
      r_snap_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_snap_valid <= 1'b1;
        r_snap_data  <= q;          // pre-update bank contents
      end else if (w_consume) begin
        r_snap_valid <= 1'b0;
      end
      // Set wins over clear when both happen in one cycle.
      if (w_drop)       r_snap_ovf <= 1'b1;
      else if (ovf_clr) r_snap_ovf <= 1'b0;
    end
  end

  assign snap_valid = r_snap_valid;
  assign snap_data  = r_snap_data;
  assign snap_ovf   = r_snap_ovf;

`ifdef D_REG_BANK_PARITY_EN
  logic [CHANNELS-1:0] r_snap_par;
  always_ff @(posedge clk) begin
    if (rst)           r_snap_par <= {CHANNELS{even_parity(PAR_MAX_W'(RESET_VAL))}};
    else if (w_accept) r_snap_par <= q_par;
  end
  assign snap_par = r_snap_par;
`else
  // Parity disabled: no snapshot parity state.
`endif

endmodule
